// File: rtl/egr_mri_req_issue.sv
// egr_mri_req_issue
//
// Request half of the egress mesh read path. Client read requests are
// arbitrated round-robin. Each request that wins gets the lowest free read
// tag and goes out to the Mesh Read Interface as a one-cycle registered
// pulse. Issue is limited by mesh request credits and by tag availability.
// When the response side reports that a tag's response has been fully
// delivered, the tag is freed. The client that originally owned the tag is
// returned on rsp_src so the response can be routed back to it.
//
// Optional feature macro: EGR_MRI_REQ_PERF_EN
//   When defined, the block adds per-client grant counters and a stall
//   counter. Both are 16-bit and saturate at 16'hFFFF.
//
// Ports:
//   cclk, rst          clock, synchronous active-high reset
//   req_valid/addr     per-client requests (client i at [i*ADDR_W +: ADDR_W])
//   req_ready          one-hot grant, combinational
//   mesh_rreq_*        registered request to the mesh (valid/addr/tag)
//   mesh_cred_ret      one mesh request credit returned
//   rsp_done_valid/tag tag whose response has completed; frees the tag
//   rsp_src_valid/src  registered owner client of the tag just freed
//   outstanding        number of tags currently allocated
//   err_sticky         [0] credit overflow, [1] free of an unallocated tag
//   perf_issue_cnt     (EGR_MRI_REQ_PERF_EN) per-client grant counts
//   perf_stall_cnt     (EGR_MRI_REQ_PERF_EN) cycles stalled with a request

module egr_mri_req_issue #(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = 20,
    parameter int TAG_W     = 4,
    parameter int MESH_CRED = 8
) (
    input  logic                       cclk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       mesh_rreq_valid,
    output logic [ADDR_W-1:0]          mesh_rreq_addr,
    output logic [TAG_W-1:0]           mesh_rreq_tag,
    input  logic                       mesh_cred_ret,
    input  logic                       rsp_done_valid,
    input  logic [TAG_W-1:0]           rsp_done_tag,
    output logic                       rsp_src_valid,
    output logic [$clog2(N_REQ)-1:0]   rsp_src,
    output logic [TAG_W:0]             outstanding,
    output logic [1:0]                 err_sticky
`ifdef EGR_MRI_REQ_PERF_EN
    ,
    output logic [N_REQ*16-1:0]        perf_issue_cnt,
    output logic [15:0]                perf_stall_cnt
`endif
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int N_TAG = 1 << TAG_W;

    logic [3:0]        r_credCnt;
    logic [N_TAG-1:0]  r_tagAlloc;
    logic [PTR_W-1:0]  r_tagSrc [N_TAG];
    logic [PTR_W-1:0]  r_rrPtr;
    logic [TAG_W:0]    r_outstanding;
    logic              r_meshValid;
    logic [ADDR_W-1:0] r_meshAddr;
    logic [TAG_W-1:0]  r_meshTag;
    logic              r_rspSrcValid;
    logic [PTR_W-1:0]  r_rspSrc;
    logic [1:0]        r_errSticky;

    logic              w_anyValid;
    logic              w_issue;
    logic [PTR_W-1:0]  w_grantIdx;
    logic              w_grantFound;
    logic [PTR_W-1:0]  w_nextPtr;
    logic [ADDR_W-1:0] w_grantAddr;
    logic [TAG_W-1:0]  w_freeTag;
    logic              w_tagFound;
    logic              w_freeOk;
    logic [N_TAG-1:0]  w_allocMask;
    logic [N_TAG-1:0]  w_freeMask;

    assign w_anyValid = |req_valid;
    // An issue needs a requester, a credit and a free tag. Only registered
    // state is used, so a tag freed this cycle cannot be reallocated until
    // the next cycle.
    assign w_issue    = w_anyValid && (r_credCnt != 4'd0) && w_tagFound;
    assign w_freeOk   = rsp_done_valid && r_tagAlloc[rsp_done_tag];

    // Search clients starting at the round-robin pointer. The first valid
    // client found wins.
    always_comb begin : rrPick
        int idx;
        idx          = 0;
        w_grantIdx   = '0;
        w_grantFound = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_rrPtr) + k) % N_REQ;
            if (!w_grantFound && req_valid[idx]) begin
                w_grantFound = 1'b1;
                w_grantIdx   = PTR_W'(idx);
            end
        end
    end

    assign w_nextPtr   = (w_grantIdx == PTR_W'(N_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
    assign w_grantAddr = req_addr[int'(w_grantIdx) * ADDR_W +: ADDR_W];

    // Find the lowest-index free tag.
    always_comb begin : tagPick
        w_freeTag  = '0;
        w_tagFound = 1'b0;
        for (int t = 0; t < N_TAG; t++) begin
            if (!w_tagFound && !r_tagAlloc[t]) begin
                w_tagFound = 1'b1;
                w_freeTag  = TAG_W'(t);
            end
        end
    end

    // The allocated tag is always free and the freed tag is always allocated,
    // so the two masks never overlap.
    always_comb begin
        w_allocMask = '0;
        w_freeMask  = '0;
        if (w_issue)  w_allocMask[w_freeTag]    = 1'b1;
        if (w_freeOk) w_freeMask[rsp_done_tag] = 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (w_issue) req_ready[w_grantIdx] = 1'b1;
    end

    // Main state. Reset returns every credit, frees all tags and drops any
    // request or response notification that is in flight.
    always_ff @(posedge cclk) begin
        if (rst) begin
            r_credCnt     <= 4'(MESH_CRED);
            r_tagAlloc    <= '0;
            r_rrPtr       <= '0;
            r_outstanding <= '0;
            r_meshValid   <= 1'b0;
            r_meshAddr    <= '0;
            r_meshTag     <= '0;
            r_rspSrcValid <= 1'b0;
            r_rspSrc      <= '0;
            r_errSticky   <= '0;
        end else begin
            r_meshValid <= w_issue;
            if (w_issue) begin
                r_meshAddr <= w_grantAddr;
                r_meshTag  <= w_freeTag;
                r_rrPtr    <= w_nextPtr;
            end

            r_tagAlloc <= (r_tagAlloc | w_allocMask) & ~w_freeMask;

            case ({w_issue, w_freeOk})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase

            // When an issue and a credit return happen in the same cycle they
            // cancel. A return while the counter is already full is an
            // overflow: the counter holds and the sticky error is set.
            if (w_issue && !mesh_cred_ret) begin
                r_credCnt <= r_credCnt - 1'b1;
            end else if (!w_issue && mesh_cred_ret) begin
                if (r_credCnt == 4'(MESH_CRED)) begin
                    r_errSticky[0] <= 1'b1;
                end else begin
                    r_credCnt <= r_credCnt + 1'b1;
                end
            end

            r_rspSrcValid <= w_freeOk;
            if (w_freeOk) begin
                r_rspSrc <= r_tagSrc[rsp_done_tag];
            end
            if (rsp_done_valid && !w_freeOk) begin
                r_errSticky[1] <= 1'b1;
            end
        end
    end

    // The owner table is only read for allocated tags, so it does not need
    // a reset.
    always_ff @(posedge cclk) begin
        if (w_issue) begin
            r_tagSrc[w_freeTag] <= w_grantIdx;
        end
    end

    assign mesh_rreq_valid = r_meshValid;
    assign mesh_rreq_addr  = r_meshAddr;
    assign mesh_rreq_tag   = r_meshTag;
    assign rsp_src_valid   = r_rspSrcValid;
    assign rsp_src         = r_rspSrc;
    assign outstanding     = r_outstanding;
    assign err_sticky      = r_errSticky;

`ifdef EGR_MRI_REQ_PERF_EN
    logic [15:0] r_perfIssue [N_REQ];
    logic [15:0] r_perfStall;

    // Saturating grant and stall counters.
    always_ff @(posedge cclk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) r_perfIssue[i] <= '0;
            r_perfStall <= '0;
        end else begin
            if (w_issue && (r_perfIssue[w_grantIdx] != 16'hFFFF)) begin
                r_perfIssue[w_grantIdx] <= r_perfIssue[w_grantIdx] + 16'd1;
            end
            if (w_anyValid && !w_issue && (r_perfStall != 16'hFFFF)) begin
                r_perfStall <= r_perfStall + 16'd1;
            end
        end
    end

    always_comb begin
        perf_issue_cnt = '0;
        for (int i = 0; i < N_REQ; i++) perf_issue_cnt[i*16 +: 16] = r_perfIssue[i];
    end
    assign perf_stall_cnt = r_perfStall;
`endif

endmodule

// File: tb/tb_egr_mri_req_issue.sv
// Testbench for egr_mri_req_issue.
// Each cycle a reference model predicts the grant. The expected mesh request
// and the expected response-source notification are pushed into queues,
// and a separate monitor pops and compares them whenever the DUT presents
// them.

module tb_egr_mri_req_issue;

    localparam int N_REQ     = 4;
    localparam int ADDR_W    = 20;
    localparam int TAG_W     = 4;
    localparam int MESH_CRED = 8;
    localparam int N_TAG     = 1 << TAG_W;
    localparam int PTR_W     = $clog2(N_REQ);

    logic                     cclk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ*ADDR_W-1:0]  req_addr = '0;
    logic [N_REQ-1:0]         req_ready;
    logic                     mesh_rreq_valid;
    logic [ADDR_W-1:0]        mesh_rreq_addr;
    logic [TAG_W-1:0]         mesh_rreq_tag;
    logic                     mesh_cred_ret = 1'b0;
    logic                     rsp_done_valid = 1'b0;
    logic [TAG_W-1:0]         rsp_done_tag = '0;
    logic                     rsp_src_valid;
    logic [PTR_W-1:0]         rsp_src;
    logic [TAG_W:0]           outstanding;
    logic [1:0]               err_sticky;
`ifdef EGR_MRI_REQ_PERF_EN
    logic [N_REQ*16-1:0]      perf_issue_cnt;
    logic [15:0]              perf_stall_cnt;
`endif

    egr_mri_req_issue #(
        .N_REQ(N_REQ), .ADDR_W(ADDR_W), .TAG_W(TAG_W), .MESH_CRED(MESH_CRED)
    ) dut (
        .cclk(cclk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .mesh_rreq_valid(mesh_rreq_valid),
        .mesh_rreq_addr(mesh_rreq_addr),
        .mesh_rreq_tag(mesh_rreq_tag),
        .mesh_cred_ret(mesh_cred_ret),
        .rsp_done_valid(rsp_done_valid),
        .rsp_done_tag(rsp_done_tag),
        .rsp_src_valid(rsp_src_valid),
        .rsp_src(rsp_src),
        .outstanding(outstanding),
        .err_sticky(err_sticky)
`ifdef EGR_MRI_REQ_PERF_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 cclk = ~cclk;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } meshExp_t;

    typedef struct {
        int                due;
        logic [PTR_W-1:0]  src;
    } rspExp_t;

    meshExp_t meshQ[$];
    rspExp_t  rspQ[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state: credits, tag ownership and the arbitration pointer.
    bit                modelKnown = 1'b0;
    int                mCredits;
    bit                mAlloc [N_TAG];
    int                mOwner [N_TAG];
    int                mPtr;
    bit                mErr0, mErr1;
    logic [ADDR_W-1:0] addrs [N_REQ];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int countAlloc();
        int n = 0;
        for (int t = 0; t < N_TAG; t++) if (mAlloc[t]) n++;
        return n;
    endfunction

    // retMode: 0 = no credit return, 1 = return, 2 = return only while the
    // model says credits are missing.
    task automatic applyStimulus(input bit rstIn, input logic [N_REQ-1:0] vIn,
                                 input int retMode, input bit dvIn, input int dtagIn);
        bit               retIn, issue, freeOk;
        int               g, ft;
        logic [N_REQ-1:0] expReady;
        @(posedge cclk);
        cycle++;
        #1;
        retIn = (retMode == 1) || (retMode == 2 && modelKnown && mCredits < MESH_CRED);
        rst            = rstIn;
        req_valid      = vIn;
        for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addrs[i];
        mesh_cred_ret  = retIn;
        rsp_done_valid = dvIn;
        rsp_done_tag   = TAG_W'(dtagIn);
        @(negedge cclk);
        if (modelKnown) begin
            checkOutput("outstanding", 64'(outstanding), 64'(countAlloc()));
            checkOutput("err_sticky", 64'(err_sticky), 64'({mErr1, mErr0}));
        end
        if (rstIn) begin
            modelKnown = 1'b1;
            mCredits   = MESH_CRED;
            mPtr       = 0;
            mErr0      = 1'b0;
            mErr1      = 1'b0;
            for (int t = 0; t < N_TAG; t++) mAlloc[t] = 1'b0;
            return;
        end
        if (!modelKnown) return;

        g = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (g < 0 && vIn[(mPtr + k) % N_REQ]) g = (mPtr + k) % N_REQ;
        end
        ft = -1;
        for (int t = N_TAG - 1; t >= 0; t--) if (!mAlloc[t]) ft = t;
        issue    = (g >= 0) && (mCredits > 0) && (ft >= 0);
        expReady = '0;
        if (issue) expReady[g] = 1'b1;
        checkOutput("req_ready", 64'(req_ready), 64'(expReady));

        freeOk = dvIn && mAlloc[dtagIn];
        if (freeOk) begin
            rspQ.push_back('{due: cycle + 1, src: PTR_W'(mOwner[dtagIn])});
            mAlloc[dtagIn] = 1'b0;
        end else if (dvIn) begin
            mErr1 = 1'b1;
        end
        if (issue) begin
            meshQ.push_back('{due: cycle + 1, addr: addrs[g], tag: TAG_W'(ft)});
            mAlloc[ft] = 1'b1;
            mOwner[ft] = g;
            mPtr       = (g + 1) % N_REQ;
        end
        if (issue && !retIn) mCredits--;
        else if (!issue && retIn) begin
            if (mCredits == MESH_CRED) mErr0 = 1'b1;
            else mCredits++;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge cclk) begin
        meshExp_t me;
        rspExp_t  re;
        if (mesh_rreq_valid === 1'b1) begin
            if (meshQ.size() == 0) begin
                checkOutput("mesh_unexpected", 64'd1, 64'd0);
            end else begin
                me = meshQ.pop_front();
                checkOutput("mesh_cycle", 64'(cycle), 64'(me.due));
                checkOutput("mesh_addr", 64'(mesh_rreq_addr), 64'(me.addr));
                checkOutput("mesh_tag", 64'(mesh_rreq_tag), 64'(me.tag));
            end
        end else if (meshQ.size() > 0 && meshQ[0].due <= cycle) begin
            me = meshQ.pop_front();
            checkOutput("mesh_missing", 64'(mesh_rreq_valid), 64'd1);
        end
        if (rsp_src_valid === 1'b1) begin
            if (rspQ.size() == 0) begin
                checkOutput("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                re = rspQ.pop_front();
                checkOutput("rsp_cycle", 64'(cycle), 64'(re.due));
                checkOutput("rsp_src", 64'(rsp_src), 64'(re.src));
            end
        end else if (rspQ.size() > 0 && rspQ[0].due <= cycle) begin
            re = rspQ.pop_front();
            checkOutput("rsp_missing", 64'(rsp_src_valid), 64'd1);
        end
    end

    initial begin
        logic [N_REQ-1:0] allV;
        logic [N_REQ-1:0] oneV;
        int               rm;
        allV = '1;
        oneV = '0;
        oneV[1] = 1'b1;
        for (int i = 0; i < N_REQ; i++) addrs[i] = ADDR_W'(32'h100 + i);

        // Round-robin order with credits recycled every cycle.
        applyStimulus(1, '0, 0, 0, 0);
        applyStimulus(1, '0, 0, 0, 0);
        applyStimulus(0, allV, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, allV, 1, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);

        // Credit exhaustion, then one returned credit.
        applyStimulus(1, '0, 0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, oneV, 0, 0, 0);
        applyStimulus(0, oneV, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, oneV, 0, 0, 0);

        // Fill all tags, free tag 5, and watch it come back.
        applyStimulus(1, '0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, allV, 2, 0, 0);
        applyStimulus(0, allV, 2, 1, 5);
        for (int i = 0; i < 3; i++) applyStimulus(0, allV, 2, 0, 0);

        // Issue, credit return and free in the same cycle.
        applyStimulus(1, '0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, allV, 2, 0, 0);
        applyStimulus(0, allV, 1, 1, 0);
        applyStimulus(0, '0, 0, 0, 0);

        // Credit overflow and a free of an unallocated tag, then reset clears both.
        applyStimulus(1, '0, 0, 0, 0);
        applyStimulus(0, '0, 1, 0, 0);
        applyStimulus(0, '0, 0, 1, 9);
        applyStimulus(0, '0, 0, 0, 0);
        applyStimulus(1, '0, 0, 0, 0);
        applyStimulus(0, '0, 0, 0, 0);

        // Reset with reads outstanding.
        for (int i = 0; i < 4; i++) applyStimulus(0, allV, 2, 0, 0);
        applyStimulus(1, allV, 0, 0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, allV, 2, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N_REQ; i++) addrs[i] = ADDR_W'($urandom);
            rm = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(0, 1)) * 2;
            applyStimulus($urandom_range(0, 299) == 0, N_REQ'($urandom), rm,
                          $urandom_range(0, 1) == 1, int'($urandom_range(0, N_TAG - 1)));
        end

        for (int i = 0; i < 3; i++) applyStimulus(0, '0, 0, 0, 0);
        checkOutput("mesh_queue_drained", 64'(meshQ.size()), 64'd0);
        checkOutput("rsp_queue_drained", 64'(rspQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
